// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage front end: owns the program counter, issues instruction-memory requests
// and delivers fetch_pc/fetch_valid, with stall, redirect (immediate or pending) and halt.
module fetch_pc_sequencer #(
    parameter int             N            = 16,
    parameter logic [N-1:0]   RESET_VECTOR = '0,
    parameter int             INC          = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_target,
    input  logic         halt,
    input  logic         imem_ready,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    output logic [N-1:0] pc,
    output logic [N-1:0] fetch_pc,
    output logic         fetch_valid,
    output logic         halted
);

    localparam logic [N-1:0] INC_N = N'(INC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        BUSY   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t       state, state_d;
    logic [N-1:0] pc_d;
    logic [N-1:0] fetch_pc_d;
    logic         fetch_valid_d;
    logic         pend_valid, pend_valid_d;
    logic [N-1:0] pend_target, pend_target_d;
    logic         halt_pend, halt_pend_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            fetch_pc    <= '0;
            fetch_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            halt_pend   <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            fetch_pc    <= fetch_pc_d;
            fetch_valid <= fetch_valid_d;
            pend_valid  <= pend_valid_d;
            pend_target <= pend_target_d;
            halt_pend   <= halt_pend_d;
        end
    end

    always_comb begin
        state_d       = state;
        pc_d          = pc;
        fetch_pc_d    = fetch_pc;
        fetch_valid_d = 1'b0;
        pend_valid_d  = pend_valid;
        pend_target_d = pend_target;
        halt_pend_d   = halt_pend;
        case (state)
            IDLE: state_d = READY;
            READY: begin
                // A redirect coinciding with a start makes the new request use the target.
                if (redirect)
                    pc_d = redirect_target;
                if (halt)
                    state_d = HALTED;
                else if (!stall)
                    state_d = BUSY;
            end
            BUSY: begin
                if (!imem_ready) begin
                    // Address must stay stable, so redirects and halts are parked until completion.
                    if (redirect) begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target;
                    end
                    if (halt)
                        halt_pend_d = 1'b1;
                end else begin
                    if (redirect) begin
                        pc_d         = redirect_target;
                        pend_valid_d = 1'b0;
                    end else if (pend_valid) begin
                        pc_d         = pend_target;
                        pend_valid_d = 1'b0;
                    end else begin
                        fetch_pc_d    = pc;
                        fetch_valid_d = 1'b1;
                        pc_d          = pc + INC_N;
                    end
                    halt_pend_d = 1'b0;
                    if (halt || halt_pend)
                        state_d = HALTED;
                    else if (stall)
                        state_d = READY;
                    else
                        state_d = BUSY;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    assign imem_req  = (state == BUSY);
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: expected fetch addresses are queued as each
// completion is set up and checked when fetch_valid pulses.
module tb_fetch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, halt, imem_ready;
    logic [15:0] redirect_target;
    logic        imem_req, fetch_valid, halted;
    logic [15:0] imem_addr, pc, fetch_pc;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_pc_sequencer #(.N(16), .RESET_VECTOR(16'h0000), .INC(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .halt(halt), .imem_ready(imem_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .fetch_pc(fetch_pc),
        .fetch_valid(fetch_valid), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later, and score any delivered fetch.
    task automatic step();
        logic [15:0] e;
        @(posedge clk);
        #1;
        if (fetch_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL fv_unexpected observed fetch_pc=%h expected no fetch_valid", fetch_pc);
            end else begin
                e = exp_q.pop_front();
                assert (fetch_pc === e) else begin
                    bad++;
                    $error("FAIL fetch_pc observed=%h expected=%h", fetch_pc, e);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 16'h0000;
        halt = 1'b0; imem_ready = 1'b1;

        // Reset then free run
        step();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_fv", fetch_valid, 0);
        chk("rst_fetch_pc", fetch_pc, 16'h0000);
        chk("rst_halted", halted, 0);
        chk("rst_req", imem_req, 0);
        rst = 1'b0;
        step();
        chk("idle_req", imem_req, 0);
        step();
        chk("busy_req", imem_req, 1);
        chk("busy_addr", imem_addr, 16'h0000);
        exp_q.push_back(16'h0000); step();
        chk("fv_pulse", fetch_valid, 1);
        exp_q.push_back(16'h0002); step();
        exp_q.push_back(16'h0004); step();
        exp_q.push_back(16'h0006); step();
        chk("free_run_q", exp_q.size(), 0);
        chk("free_run_pc", pc, 16'h0008);

        // Memory wait with redirect
        redirect = 1'b1; redirect_target = 16'h0010; step();
        redirect = 1'b0;
        chk("redir_pc", pc, 16'h0010);
        chk("redir_fv", fetch_valid, 0);
        imem_ready = 1'b0; step();
        chk("wait1_addr", imem_addr, 16'h0010);
        redirect = 1'b1; redirect_target = 16'h0100; step();
        redirect = 1'b0;
        chk("wait2_addr", imem_addr, 16'h0010);
        chk("wait2_pc", pc, 16'h0010);
        step();
        chk("wait3_addr", imem_addr, 16'h0010);
        chk("wait3_req", imem_req, 1);
        imem_ready = 1'b1; step();
        chk("pend_pc", pc, 16'h0100);
        chk("pend_fv", fetch_valid, 0);
        exp_q.push_back(16'h0100); step();
        chk("pend_q", exp_q.size(), 0);

        // Pending overwrite, then input redirect beating a pending one
        imem_ready = 1'b0; redirect = 1'b1; redirect_target = 16'h0180; step();
        redirect_target = 16'h0200; step();
        redirect = 1'b0; imem_ready = 1'b1; step();
        chk("overwrite_pc", pc, 16'h0200);
        imem_ready = 1'b0; redirect = 1'b1; redirect_target = 16'h0250; step();
        imem_ready = 1'b1; redirect_target = 16'h0300; step();
        redirect = 1'b0;
        chk("prio_pc", pc, 16'h0300);
        chk("prio_fv", fetch_valid, 0);
        exp_q.push_back(16'h0300); step();
        chk("pend_cleared_pc", pc, 16'h0302);

        // Stall while busy
        imem_ready = 1'b0; stall = 1'b1; step();
        chk("stall_req1", imem_req, 1);
        chk("stall_addr", imem_addr, 16'h0302);
        step();
        chk("stall_req2", imem_req, 1);
        imem_ready = 1'b1; exp_q.push_back(16'h0302); step();
        chk("stall_done_req", imem_req, 0);
        chk("stall_done_pc", pc, 16'h0304);
        step();
        chk("stall_ready_req", imem_req, 0);
        stall = 1'b0; step();
        chk("unstall_req", imem_req, 1);
        chk("unstall_addr", imem_addr, 16'h0304);
        exp_q.push_back(16'h0304); step();

        // Halt
        imem_ready = 1'b0; halt = 1'b1; step();
        halt = 1'b0; step();
        chk("halt_wait_req", imem_req, 1);
        chk("halt_wait_halted", halted, 0);
        imem_ready = 1'b1; exp_q.push_back(16'h0306); step();
        chk("halt_fv", fetch_valid, 1);
        chk("halted", halted, 1);
        chk("halted_req", imem_req, 0);
        chk("halted_pc", pc, 16'h0308);
        redirect = 1'b1; redirect_target = 16'h0400; halt = 1'b1; step();
        redirect = 1'b0; halt = 1'b0;
        chk("halted_ign_pc", pc, 16'h0308);
        chk("halted_stay", halted, 1);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("halt_rst_pc", pc, 16'h0000);
        chk("halt_rst_halted", halted, 0);

        // Wrap-around
        step();
        redirect = 1'b1; redirect_target = 16'hFFFE; step();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 16'hFFFE);
        chk("wrap_req", imem_req, 1);
        exp_q.push_back(16'hFFFE); step();
        chk("wrap_pc", pc, 16'h0000);

        // Reset mid-transaction drops pending redirect and halt
        imem_ready = 1'b0; step();
        redirect = 1'b1; redirect_target = 16'h0500; halt = 1'b1; step();
        redirect = 1'b0; halt = 1'b0;
        rst = 1'b1; step();
        rst = 1'b0; imem_ready = 1'b1;
        chk("midrst_req", imem_req, 0);
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_halted", halted, 0);
        step();
        step();
        chk("post_rst_addr", imem_addr, 16'h0000);
        exp_q.push_back(16'h0000); step();
        chk("post_rst_pc", pc, 16'h0002);
        chk("post_rst_halted", halted, 0);
        chk("final_q", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
